// File: rtl/ins_dec_pipe.sv
// Registered instruction-decode stage: valid/ready handshakes on both sides,
// a shift-register RAW scoreboard that stalls fetch, and a flush for taken jumps.
module ins_dec_pipe #(
    parameter int DATA_W    = 4,
    parameter int REG_AW    = 2,
    parameter int HAZ_DEPTH = 2,
    localparam int INS_W    = 3 + 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INS_W-1:0]  INS,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel_data,
    output logic              write_en,
    output logic              alu_op,
    output logic [REG_AW-1:0] SEL_A,
    output logic [REG_AW-1:0] SEL_B,
    output logic [REG_AW-1:0] SEL_W,
    output logic [DATA_W-1:0] IMM,
    output logic [DATA_W-1:0] JMP,
    output logic              jmp_valid,
    output logic              stall
);

    logic [2:0]        dec_opc;
    logic              dec_sel_data;
    logic              dec_write_en;
    logic              dec_alu_op;
    logic              dec_jmp_valid;
    logic [REG_AW-1:0] dec_sel_a;
    logic [REG_AW-1:0] dec_sel_b;
    logic [REG_AW-1:0] dec_sel_w;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] dec_jmp;

    logic              out_valid_q, out_valid_d;
    logic              sel_data_q, sel_data_d;
    logic              write_en_q, write_en_d;
    logic              alu_op_q, alu_op_d;
    logic              jmp_valid_q, jmp_valid_d;
    logic [REG_AW-1:0] sel_a_q, sel_a_d;
    logic [REG_AW-1:0] sel_b_q, sel_b_d;
    logic [REG_AW-1:0] sel_w_q, sel_w_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] jmp_q, jmp_d;

    logic [HAZ_DEPTH-1:0] sb_v_q, sb_v_d;
    logic [REG_AW-1:0]    sb_a_q [HAZ_DEPTH];
    logic [REG_AW-1:0]    sb_a_d [HAZ_DEPTH];

    logic hazard;
    logic hit;
    logic accept;
    logic xfer;

    always_comb begin
        dec_opc       = INS[INS_W-1 -: 3];
        dec_sel_data  = dec_opc[1];
        dec_write_en  = !((dec_opc == 3'b011) || (dec_opc == 3'b100));
        dec_jmp_valid = (dec_opc == 3'b100);
        dec_alu_op    = INS[2*DATA_W-2];
        dec_sel_b     = INS[REG_AW-1:0];
        dec_sel_a     = INS[2*REG_AW-1:REG_AW];
        dec_sel_w     = INS[DATA_W+REG_AW-1:DATA_W];
        dec_imm       = INS[DATA_W-1:0];
        dec_jmp       = INS[2*DATA_W-1:DATA_W];
    end

    // B only counts as a source when the immediate is not selected.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_v_q[i] && ((sb_a_q[i] == dec_sel_a) ||
                              (!dec_sel_data && (sb_a_q[i] == dec_sel_b)))) begin
                hit = 1'b1;
            end
        end
        if (out_valid_q && write_en_q && ((sel_w_q == dec_sel_a) ||
                                          (!dec_sel_data && (sel_w_q == dec_sel_b)))) begin
            hit = 1'b1;
        end
        hazard   = in_valid && hit;
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
        stall    = hazard;
        accept   = in_valid && in_ready;
        xfer     = out_valid_q && out_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sel_data_d  = sel_data_q;
        write_en_d  = write_en_q;
        alu_op_d    = alu_op_q;
        jmp_valid_d = jmp_valid_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        sel_w_d     = sel_w_q;
        imm_d       = imm_q;
        jmp_d       = jmp_q;
        if (accept) begin
            out_valid_d = 1'b1;
            sel_data_d  = dec_sel_data;
            write_en_d  = dec_write_en;
            alu_op_d    = dec_alu_op;
            jmp_valid_d = dec_jmp_valid;
            sel_a_d     = dec_sel_a;
            sel_b_d     = dec_sel_b;
            sel_w_d     = dec_sel_w;
            imm_d       = dec_imm;
            jmp_d       = dec_jmp;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A write enters the scoreboard only when it actually leaves this stage.
    always_comb begin
        sb_v_d[0] = xfer && write_en_q;
        sb_a_d[0] = (xfer && write_en_q) ? sel_w_q : '0;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            sb_v_d[i] = sb_v_q[i-1];
            sb_a_d[i] = sb_a_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sel_data_q  <= 1'b0;
            write_en_q  <= 1'b0;
            alu_op_q    <= 1'b0;
            jmp_valid_q <= 1'b0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            sel_w_q     <= '0;
            imm_q       <= '0;
            jmp_q       <= '0;
            sb_v_q      <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                sb_a_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            sel_data_q  <= sel_data_d;
            write_en_q  <= write_en_d;
            alu_op_q    <= alu_op_d;
            jmp_valid_q <= jmp_valid_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            sel_w_q     <= sel_w_d;
            imm_q       <= imm_d;
            jmp_q       <= jmp_d;
            sb_v_q      <= sb_v_d;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                sb_a_q[i] <= sb_a_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sel_data  = sel_data_q;
    assign write_en  = write_en_q;
    assign alu_op    = alu_op_q;
    assign jmp_valid = jmp_valid_q;
    assign SEL_A     = sel_a_q;
    assign SEL_B     = sel_b_q;
    assign SEL_W     = sel_w_q;
    assign IMM       = imm_q;
    assign JMP       = jmp_q;

endmodule

// File: tb/tb_ins_dec_pipe.sv
// Directed bench for ins_dec_pipe: default build plus a DATA_W=8/REG_AW=3/HAZ_DEPTH=4 build.
module tb_ins_dec_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        d0_iv, d0_irdy, d0_fl, d0_ov, d0_ordy;
    logic [10:0] d0_ins;
    logic        d0_sd, d0_we, d0_alu, d0_jv, d0_stall;
    logic [1:0]  d0_sa, d0_sb, d0_sw;
    logic [3:0]  d0_imm, d0_jmp;

    logic        d1_iv, d1_irdy, d1_fl, d1_ov, d1_ordy;
    logic [18:0] d1_ins;
    logic        d1_sd, d1_we, d1_alu, d1_jv, d1_stall;
    logic [2:0]  d1_sa, d1_sb, d1_sw;
    logic [7:0]  d1_imm, d1_jmp;

    ins_dec_pipe u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(d0_iv), .in_ready(d0_irdy), .INS(d0_ins),
        .flush(d0_fl), .out_valid(d0_ov), .out_ready(d0_ordy), .sel_data(d0_sd),
        .write_en(d0_we), .alu_op(d0_alu), .SEL_A(d0_sa), .SEL_B(d0_sb), .SEL_W(d0_sw),
        .IMM(d0_imm), .JMP(d0_jmp), .jmp_valid(d0_jv), .stall(d0_stall)
    );

    ins_dec_pipe #(.DATA_W(8), .REG_AW(3), .HAZ_DEPTH(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_iv), .in_ready(d1_irdy), .INS(d1_ins),
        .flush(d1_fl), .out_valid(d1_ov), .out_ready(d1_ordy), .sel_data(d1_sd),
        .write_en(d1_we), .alu_op(d1_alu), .SEL_A(d1_sa), .SEL_B(d1_sb), .SEL_W(d1_sw),
        .IMM(d1_imm), .JMP(d1_jmp), .jmp_valid(d1_jv), .stall(d1_stall)
    );

    // Packed field views: {sel_data, write_en, alu_op, jmp_valid, SEL_W, SEL_A, SEL_B, IMM, JMP}
    function automatic logic [31:0] f0();
        return 32'({d0_sd, d0_we, d0_alu, d0_jv, d0_sw, d0_sa, d0_sb, d0_imm, d0_jmp});
    endfunction

    function automatic logic [31:0] f1();
        return 32'({d1_sd, d1_we, d1_alu, d1_jv, d1_sw, d1_sa, d1_sb, d1_imm, d1_jmp});
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0(input int n);
        d0_iv = 1'b0;
        repeat (n) step();
    endtask

    logic [10:0] vins [8] = '{
        11'b000_0111_1000, 11'b001_1011_0010, 11'b010_0011_1010, 11'b011_1111_0000,
        11'b100_1001_1000, 11'b101_0111_0010, 11'b110_1011_1000, 11'b111_0111_1010
    };
    logic [17:0] vexp [8] = '{
        {4'b0110, 2'd3, 2'd2, 2'd0, 4'd8,  4'd7},
        {4'b0100, 2'd3, 2'd0, 2'd2, 4'd2,  4'd11},
        {4'b1100, 2'd3, 2'd2, 2'd2, 4'd10, 4'd3},
        {4'b1010, 2'd3, 2'd0, 2'd0, 4'd0,  4'd15},
        {4'b0001, 2'd1, 2'd2, 2'd0, 4'd8,  4'd9},
        {4'b0110, 2'd3, 2'd0, 2'd2, 4'd2,  4'd7},
        {4'b1100, 2'd3, 2'd2, 2'd0, 4'd8,  4'd11},
        {4'b1110, 2'd3, 2'd2, 2'd2, 4'd10, 4'd7}
    };

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        d0_iv = 1'b0; d0_ins = '0; d0_fl = 1'b0; d0_ordy = 1'b1;
        d1_iv = 1'b0; d1_ins = '0; d1_fl = 1'b0; d1_ordy = 1'b1;
        #3;
        chk("rst_ov0", 32'(d0_ov), 32'd0);
        chk("rst_fld0", f0(), 32'd0);
        chk("rst_ov1", 32'(d1_ov), 32'd0);
        chk("rst_fld1", f1(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first instruction after reset release
        d0_iv = 1'b1; d0_ins = 11'b000_0001_0110;
        #1 chk("rel_rdy", 32'(d0_irdy), 32'd1);
        step();
        chk("rel_ov", 32'(d0_ov), 32'd1);
        chk("rel_fld", f0(), 32'({4'b0100, 2'd1, 2'd1, 2'd2, 4'd6, 4'd1}));

        // independent stream, one per cycle
        for (int k = 0; k < 8; k++) begin
            d0_ins = vins[k];
            #1 chk("str_rdy", 32'(d0_irdy), 32'd1);
            step();
            chk("str_ov", 32'(d0_ov), 32'd1);
            chk($sformatf("str_fld%0d", k), f0(), 32'(vexp[k]));
        end
        idle0(4);
        chk("drain_ov", 32'(d0_ov), 32'd0);

        // RAW on A: producer writes R2, consumer reads R2
        d0_iv = 1'b1; d0_ins = 11'b000_0010_0000;
        #1 chk("haz_p_rdy", 32'(d0_irdy), 32'd1);
        step();
        d0_ins = 11'b000_0000_1000;
        #1 chk("haz_held_stall", 32'(d0_stall), 32'd1);
        chk("haz_held_rdy", 32'(d0_irdy), 32'd0);
        step();
        n = 0;
        while (d0_stall && n < 20) begin
            n++;
            step();
        end
        chk("haz_cycles", 32'(n), 32'd2);
        chk("haz_rdy", 32'(d0_irdy), 32'd1);
        step();
        chk("haz_ov", 32'(d0_ov), 32'd1);
        chk("haz_fld", f0(), 32'({4'b0100, 2'd0, 2'd2, 2'd0, 4'd8, 4'd0}));
        idle0(5);

        // immediate-selecting consumer whose IMM low bits name R2: no stall
        d0_iv = 1'b1; d0_ins = 11'b000_0010_0000;
        step();
        d0_ins = 11'b010_0000_0010;
        #1 chk("imm_stall", 32'(d0_stall), 32'd0);
        chk("imm_rdy", 32'(d0_irdy), 32'd1);
        step();
        chk("imm_fld", f0(), 32'({4'b1100, 2'd0, 2'd0, 2'd2, 4'd2, 4'd0}));
        idle0(5);

        // backpressure for 3 cycles, dependent consumer waiting behind it
        d0_ordy = 1'b0;
        d0_iv = 1'b1; d0_ins = 11'b001_1101_1000;
        #1 chk("bp_rdy0", 32'(d0_irdy), 32'd1);
        step();
        d0_ins = 11'b000_0000_0100;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_rdy", 32'(d0_irdy), 32'd0);
            chk("bp_ov", 32'(d0_ov), 32'd1);
            chk("bp_fld", f0(), 32'({4'b0110, 2'd1, 2'd2, 2'd0, 4'd8, 4'd13}));
            step();
        end
        d0_ordy = 1'b1;
        step();
        n = 0;
        while (d0_stall && n < 20) begin
            n++;
            step();
        end
        chk("bp_haz_cycles", 32'(n), 32'd2);
        step();
        chk("bp_cons_fld", f0(), 32'({4'b0100, 2'd0, 2'd1, 2'd0, 4'd4, 4'd0}));
        idle0(5);

        // flush a held jump
        d0_ordy = 1'b0;
        d0_iv = 1'b1; d0_ins = 11'b100_0110_0000;
        #1 chk("fl_j_rdy", 32'(d0_irdy), 32'd1);
        step();
        chk("fl_j_fld", f0(), 32'({4'b0011, 2'd2, 2'd0, 2'd0, 4'd0, 4'd6}));
        d0_fl = 1'b1; d0_ins = 11'b000_1100_0000;
        #1 chk("fl_rdy", 32'(d0_irdy), 32'd0);
        step();
        d0_fl = 1'b0;
        chk("fl_ov", 32'(d0_ov), 32'd0);
        #1 chk("fl_resend_rdy", 32'(d0_irdy), 32'd1);
        step();
        chk("fl_resend_ov", 32'(d0_ov), 32'd1);
        chk("fl_resend_fld", f0(), 32'({4'b0110, 2'd0, 2'd0, 2'd0, 4'd0, 4'd12}));

        // reset while a consumer is stalled on a scoreboard entry
        d0_ins = 11'b000_0000_0000;
        d0_ordy = 1'b1;
        #1 chk("rs_held_stall", 32'(d0_stall), 32'd1);
        step();
        chk("rs_sb_stall", 32'(d0_stall), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rs_ov", 32'(d0_ov), 32'd0);
        chk("rs_fld", f0(), 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("rs_rdy", 32'(d0_irdy), 32'd1);
        chk("rs_stall", 32'(d0_stall), 32'd0);
        step();
        chk("rs_acc_ov", 32'(d0_ov), 32'd1);
        chk("rs_acc_fld", f0(), 32'({4'b0100, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0}));
        idle0(3);

        // wide build: producer writes R5, consumer reads R5 through B
        d1_iv = 1'b1; d1_ins = {3'b000, 8'h45, 8'h1A};
        #1 chk("w_p_rdy", 32'(d1_irdy), 32'd1);
        step();
        chk("w_p_fld", f1(), 32'({4'b0110, 3'd5, 3'd3, 3'd2, 8'h1A, 8'h45}));
        d1_ins = {3'b001, 8'h00, 8'h05};
        #1 chk("w_held_stall", 32'(d1_stall), 32'd1);
        step();
        n = 0;
        while (d1_stall && n < 20) begin
            n++;
            step();
        end
        chk("w_haz_cycles", 32'(n), 32'd4);
        step();
        chk("w_c_fld", f1(), 32'({4'b0100, 3'd0, 3'd0, 3'd5, 8'h05, 8'h00}));
        d1_iv = 1'b0;
        repeat (6) step();
        d1_iv = 1'b1; d1_ins = {3'b100, 8'hA7, 8'h00};
        #1 chk("w_j_rdy", 32'(d1_irdy), 32'd1);
        step();
        chk("w_j_fld", f1(), 32'({4'b0001, 3'd7, 3'd0, 3'd0, 8'h00, 8'hA7}));
        d1_iv = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ins_dec_pipe.md
# ins_dec_pipe

Registered, parametrised instruction-decode stage for the CPU datapath. Sits between instruction fetch and the register file/ALU. Decodes one instruction word per cycle into the same control fields as the combinational decoder: sel_data, write_en, alu_op, SEL_A/B/W, IMM and JMP. Adds valid/ready handshakes, a read-after-write hazard scoreboard that stalls fetch, and a flush input for taken jumps.

## Interface
- DATA_W, 4, datapath and immediate width; also the JMP target width.
- REG_AW, 2, register address width. Constraint: 2*REG_AW <= DATA_W-1.
- HAZ_DEPTH, 2, cycles from issue until the register-file write is visible to readers (1..8).
- INS_W, 3+2*DATA_W (derived, do not override), instruction width; 11 at defaults.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents INS.
- in_ready  out  1  stage accepts INS this cycle.
- INS  in  INS_W  instruction word.
- flush  in  1  kill the held instruction and refuse input this cycle.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  execute consumes the decoded fields.
- sel_data, write_en, alu_op  out  1 each  decoded controls.
- SEL_A, SEL_B, SEL_W  out  REG_AW each  register addresses.
- IMM  out  DATA_W  immediate.
- JMP  out  DATA_W  jump target.
- jmp_valid  out  1  held instruction is a jump.
- stall  out  1  hazard is blocking acceptance this cycle.

## Operation
- Field map (OPC = INS[INS_W-1:INS_W-3]):
  - IMM = INS[DATA_W-1:0]
  - SEL_B = INS[REG_AW-1:0]
  - SEL_A = INS[2*REG_AW-1:REG_AW]
  - SEL_W = INS[DATA_W+REG_AW-1:DATA_W]
  - alu_op = INS[2*DATA_W-2]
  - JMP = INS[2*DATA_W-1:DATA_W]
  - sel_data = OPC[1]
- write_en = 0 for OPC 3'b011 and 3'b100; 1 otherwise. jmp_valid = (OPC==3'b100).
- Source use: A is always read. B is read only when sel_data==0 (sel_data==1 selects IMM).
- Scoreboard: HAZ_DEPTH entries of {v, addr}.
  - Shifts one place every cycle. The oldest entry drops.
  - The new entry is {1, SEL_W} when an output transfer (out_valid&&out_ready) carries write_en==1; otherwise {0, 0}.
- hazard = in_valid and INS reads A (or B, when used) equal to addr of any valid scoreboard entry, or equal to SEL_W of the held output when out_valid&&write_en.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. stall = hazard && in_valid.
- Accept (in_valid&&in_ready): all output fields are registered from INS and out_valid<=1.
- Output drained with no accept: out_valid<=0. Fields hold their last values.
- Output held (out_valid && !out_ready): fields are stable.
- flush: out_valid<=0 next edge, regardless of out_ready. The scoreboard still shifts normally. An instruction transferring in the flush cycle is still recorded.

## Timing
- Latency 1 cycle: INS accepted at edge N appears on outputs after edge N.
- Throughput 1/cycle with no hazards.
- Back-to-back dependent instructions stall for exactly HAZ_DEPTH cycles after the producer transfers, plus any cycles the producer itself is held.
- in_ready and stall are combinational from INS, in_valid, flush, out_ready and state. Registered outputs have no combinational path from inputs.
- Reset (rst_n low, asynchronous): out_valid=0, all fields=0, jmp_valid=0, all scoreboard entries cleared. in_ready reads 1 once rst_n is high, provided in_valid=0 or no hazard.
- Reset mid-stall: the pending instruction is discarded and the scoreboard is empty afterward.
- flush and accept in the same cycle: accept is suppressed (flush wins).

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0 immediately. After release with in_valid=1 and INS=11'b000_0001_0110, the outputs after the next edge are SEL_W=1, SEL_A=1, SEL_B=2, write_en=1, sel_data=0, alu_op=0.
- Streaming: 8 independent instructions with out_ready=1 → one output per cycle. OPC 3'b011 and 3'b100 give write_en=0; OPC 3'b100 gives jmp_valid=1 and JMP=INS[7:4].
- RAW hazard (HAZ_DEPTH=2): producer writes R2, then a consumer reads A=R2 → stall=1 and in_ready=0 for 2 cycles after the producer transfers, then the consumer is accepted. Consumer with sel_data=1 and IMM low bits = R2 → no stall.
- Backpressure: out_ready=0 for 3 cycles → outputs stable, in_ready=0, and no scoreboard entry is added until transfer.
- Flush: flush=1 with a held jump → out_valid=0 next cycle, the input offered that cycle is not accepted, and the fetch resend is accepted one cycle later.
- Parametrised build: DATA_W=8, REG_AW=3, HAZ_DEPTH=4, INS_W=19 → field extraction is correct and the dependent stall is 4 cycles.
